accum_add_sub_n_bits: RTL and testbench
=======================================

// Module: accum_add_sub_n_bits
// PURPOSE
//  Parametrised N-bit accumulating adder/subtractor, successor to the fixed 8-bit
//  stored-operand adder. Each accepted input beat is loaded into, added to or
//  subtracted from the accumulator. Up to OPS_MAX beats form one batch; the block
//  then holds the result and raises done. Sits between the input capture stage and
//  the display/result logic. Exposes operands, result and carry/overflow/zero flags.
// PARAMETERS
//  N         8  data width of in, A, B and S
//  OPS_MAX   4  accepted beats per batch (>=1); CW = $clog2(OPS_MAX+1)
//  SATURATE  0  0: wrap modulo 2^N; 1: clamp unsigned (add->2^N-1, sub->0)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   begin new batch: clear acc and count
//  in_valid  in   1   input beat offered
//  in_ready  out  1   block accepts beat this cycle
//  mode      in   2   00 load, 01 add, 10 sub, 11 no-op (beat counted only)
//  in        in   N   input operand
//  A         out  N   stored operand (= accumulator)
//  B         out  N   current input (= in, combinational)
//  S         out  N   result (= accumulator, registered)
//  cout      out  1   unsigned carry (add) / borrow (sub) of last accepted op
//  ovf       out  1   two's-complement overflow of last accepted op
//  zero      out  1   accumulator == 0 (combinational from acc)
//  count     out  CW  accepted beats in current batch
//  done      out  1   batch complete, result held
// BEHAVIOUR
//  Reset (async, immediate, also mid-batch): state IDLE, acc=0, cout=0, ovf=0,
//    count=0, done=0, zero=1, in_ready=0.
//  FSM states and transitions:
//    IDLE -> RUN on start.
//    RUN  -> DONE on the accepted beat that makes count==OPS_MAX.
//    DONE -> RUN on start.
//  Entering RUN via start: acc, count, cout and ovf are cleared and done=0.
//  in_ready = (state==RUN) & ~start. start has priority: a beat offered in the
//    start cycle is dropped. Accept = in_valid & in_ready.
//  Latency: S, A and flags update on the clock edge after acceptance (1 cycle).
//  On accept, count increments by 1:
//    load:   acc<=in; cout<=0; ovf<=0.
//    add:    sum[N:0]={0,acc}+{0,in}; cout<=sum[N];
//            ovf<=(acc[N-1]==in[N-1])&(sum[N-1]!=acc[N-1]).
//    sub:    dif[N:0]={0,acc}-{0,in}; cout<=dif[N] (borrow, in>acc);
//            ovf<=(acc[N-1]!=in[N-1])&(dif[N-1]!=acc[N-1]).
//    no-op:  acc and flags unchanged.
//  acc gets sum[N-1:0] / dif[N-1:0]. If SATURATE=1 and cout=1, acc gets
//    {N{1}} for add and 0 for sub. Flags still report the raw carry or borrow.
//  No accept (in_valid low, IDLE, DONE): all registers hold.
//  DONE: done=1, in_ready=0, S held. in_valid is ignored until start.
//  start while RUN restarts the batch; the partial result is discarded.
// TESTING
//  1 N=8: start; load 200, add 100 -> S=44, cout=1, ovf=0, count=2.
//  2 N=8: load 100, add 100 -> S=200, cout=0, ovf=1.
//    Then sub 201 -> S=255, cout=1 (borrow), ovf=0.
//  3 SATURATE=1: load 200, add 100 -> S=255, cout=1.
//    Then load 5, sub 7 -> S=0, cout=1.
//  4 OPS_MAX=4: 4 beats, in_valid gaps between them -> done=1 one cycle after the
//    4th accept; a 5th beat leaves S unchanged (in_ready=0); start -> S=0,
//    count=0, done=0, zero=1.
//  5 start coincident with in_valid in RUN -> beat dropped, count=0, acc=0.
//  6 reset asserted mid-batch (count=2, S=44), asynchronous to clk -> outputs go
//    immediately to reset values; after release, in_valid ignored until start.

Source files
------------

// File: rtl/accum_add_sub_n_bits.sv
// -----------------------------------------------------------------------------
// accum_add_sub_n_bits
//
// Parametrised N-bit accumulating adder/subtractor. A batch is opened with
// `start`, which clears the accumulator, the beat counter and the flags. Each
// accepted beat (in_valid & in_ready) then loads, adds to, subtracts from or
// leaves the accumulator unchanged. The beat is counted in every case. When
// OPS_MAX beats have been accepted, the block holds the result and raises
// `done` until the next `start`.
//
// Parameters
//   N         data width of in, A, B and S
//   OPS_MAX   accepted beats per batch (>= 1)
//   SATURATE  0: wrap modulo 2^N, 1: clamp unsigned (add -> 2^N-1, sub -> 0)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     open a new batch (has priority over a beat in the same cycle)
//   in_valid  input beat offered
//   in_ready  beat can be accepted this cycle (RUN and no start)
//   mode      00 load, 01 add, 10 sub, 11 no-op (beat only counted)
//   in        input operand
//   A         stored operand (accumulator)
//   B         current input operand (combinational copy of in)
//   S         result (accumulator, registered)
//   cout      unsigned carry (add) / borrow (sub) of the last accepted op
//   ovf       two's-complement overflow of the last accepted op
//   zero      accumulator == 0
//   count     accepted beats in the current batch
//   done      batch complete, result held
// -----------------------------------------------------------------------------
module accum_add_sub_n_bits #(
  parameter int N        = 8,
  parameter int OPS_MAX  = 4,
  parameter bit SATURATE = 1'b0,
  localparam int CW      = $clog2(OPS_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic [N-1:0]  S,
  output logic          cout,
  output logic          ovf,
  output logic          zero,
  output logic [CW-1:0] count,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;

  localparam logic [CW-1:0] COUNT_LAST = CW'(OPS_MAX);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);

  // Signed overflow of a+b: operands agree in sign, result sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) & (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) & (r_msb != a_msb);
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  acc_r;
  logic [N-1:0]  acc_nxt_s;
  logic          cout_r;
  logic          cout_nxt_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          done_r;
  logic [N:0]    sum_s;
  logic [N:0]    dif_s;
  logic          in_ready_s;
  logic          accept_s;

  // Handshake: start wins over a beat offered in the same cycle.
  always_comb begin
    in_ready_s = (state_r == RUN) & ~start;
    accept_s   = in_valid & in_ready_s;
  end

  // Datapath next values: N+1-bit arithmetic exposes carry/borrow in the MSB.
  always_comb begin
    sum_s       = {1'b0, acc_r} + {1'b0, in};
    dif_s       = {1'b0, acc_r} - {1'b0, in};
    acc_nxt_s   = acc_r;
    cout_nxt_s  = cout_r;
    ovf_nxt_s   = ovf_r;
    count_nxt_s = count_r;
    if (start) begin
      acc_nxt_s   = {N{1'b0}};
      cout_nxt_s  = 1'b0;
      ovf_nxt_s   = 1'b0;
      count_nxt_s = {CW{1'b0}};
    end else if (accept_s) begin
      count_nxt_s = count_r + COUNT_ONE;
      case (mode)
        MODE_LOAD: begin
          acc_nxt_s  = in;
          cout_nxt_s = 1'b0;
          ovf_nxt_s  = 1'b0;
        end
        MODE_ADD: begin
          cout_nxt_s = sum_s[N];
          ovf_nxt_s  = add_ovf(acc_r[N-1], in[N-1], sum_s[N-1]);
          // Flags keep the raw carry even when the stored value is clamped.
          if (SATURATE && sum_s[N]) begin
            acc_nxt_s = {N{1'b1}};
          end else begin
            acc_nxt_s = sum_s[N-1:0];
          end
        end
        MODE_SUB: begin
          cout_nxt_s = dif_s[N];
          ovf_nxt_s  = sub_ovf(acc_r[N-1], in[N-1], dif_s[N-1]);
          if (SATURATE && dif_s[N]) begin
            acc_nxt_s = {N{1'b0}};
          end else begin
            acc_nxt_s = dif_s[N-1:0];
          end
        end
        default: begin
          // No-op beat: only the counter advances.
          acc_nxt_s  = acc_r;
          cout_nxt_s = cout_r;
          ovf_nxt_s  = ovf_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FSM next state: any start (re)opens a batch; the last beat closes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (start) begin
          state_nxt_s = RUN;
        end else if (accept_s && (count_nxt_s == COUNT_LAST)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator, flags, counter and done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r   <= {N{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      count_r <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      cout_r  <= cout_nxt_s;
      ovf_r   <= ovf_nxt_s;
      count_r <= count_nxt_s;
      done_r  <= (state_nxt_s == DONE);
    end
  end

  assign in_ready = in_ready_s;
  assign A        = acc_r;
  assign B        = in;
  assign S        = acc_r;
  assign cout     = cout_r;
  assign ovf      = ovf_r;
  assign zero     = (acc_r == {N{1'b0}});
  assign count    = count_r;
  assign done     = done_r;

endmodule

// File: tb/tb_accum_add_sub_n_bits.sv
// -----------------------------------------------------------------------------
// tb_accum_add_sub_n_bits
//
// Drives a wrapping (SATURATE=0) and a clamping (SATURATE=1) instance with the
// same stimulus. The driver runs an integer reference model of the batch rules
// and pushes the expected result of every start/accepted beat into a queue; a
// monitor pops an entry whenever the DUT takes a start or handshake and
// compares all outputs one cycle later.
// -----------------------------------------------------------------------------
module tb_accum_add_sub_n_bits;

  localparam int N   = 8;
  localparam int OPS = 4;
  localparam int CW  = $clog2(OPS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [1:0]    mode;
  logic [N-1:0]  din;

  logic          rdy0, rdy1, c0, c1, o0, o1, z0, z1, d0, d1;
  logic [N-1:0]  A0, A1, B0, B1, S0, S1;
  logic [CW-1:0] cnt0, cnt1;

  accum_add_sub_n_bits #(.N(N), .OPS_MAX(OPS), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .mode(mode), .in(din), .A(A0), .B(B0), .S(S0), .cout(c0), .ovf(o0),
    .zero(z0), .count(cnt0), .done(d0)
  );

  accum_add_sub_n_bits #(.N(N), .OPS_MAX(OPS), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .mode(mode), .in(din), .A(A1), .B(B1), .S(S1), .cout(c1), .ovf(o1),
    .zero(z1), .count(cnt1), .done(d1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0;
    int s1;
    bit c0;
    bit c1;
    bit o0;
    bit o1;
    int cnt;
    bit dn;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: index 0 wrapping, index 1 clamping.
  int   m_acc[2];
  bit   m_cout[2];
  bit   m_ovf[2];
  int   m_cnt;
  bit   m_run;
  bit   m_done;
  bit   exp_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
  endfunction

  function automatic bit sovf(input int v);
    return (v > (1 << (N - 1)) - 1) || (v < -(1 << (N - 1)));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    m_cnt = 0; m_run = 1'b0; m_done = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.s0 = m_acc[0]; e.s1 = m_acc[1];
    e.c0 = m_cout[0]; e.c1 = m_cout[1];
    e.o0 = m_ovf[0]; e.o1 = m_ovf[1];
    e.cnt = m_cnt; e.dn = m_done;
    sbq.push_back(e);
  endtask

  // Batch rules in plain integer arithmetic.
  task automatic model_apply(input bit st, input bit v, input logic [1:0] md, input int x);
    int r;
    exp_ready = m_run && !st;
    if (st) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
      end
      m_cnt = 0; m_run = 1'b1; m_done = 1'b0;
      push_exp();
    end else if (exp_ready && v) begin
      m_cnt++;
      for (int k = 0; k < 2; k++) begin
        case (md)
          2'b00: begin
            m_acc[k] = x; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
          end
          2'b01: begin
            r = m_acc[k] + x;
            m_cout[k] = (r >= (1 << N));
            m_ovf[k]  = sovf(sgn(m_acc[k]) + sgn(x));
            m_acc[k]  = (m_cout[k] && k == 1) ? (1 << N) - 1 : r % (1 << N);
          end
          2'b10: begin
            r = m_acc[k] - x;
            m_cout[k] = (r < 0);
            m_ovf[k]  = sovf(sgn(m_acc[k]) - sgn(x));
            m_acc[k]  = (m_cout[k] && k == 1) ? 0 : (r + (1 << N)) % (1 << N);
          end
          default: ;
        endcase
      end
      if (m_cnt == OPS) begin
        m_run = 1'b0; m_done = 1'b1;
      end
      push_exp();
    end
  endtask

  task automatic beat(input bit st, input bit v, input logic [1:0] md, input int x);
    @(posedge clk);
    #2;
    start = st; in_valid = v; mode = md; din = x[N-1:0];
    model_apply(st, v, md, x);
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 2'b11, 0);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic async_reset();
    idle();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_S", S0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_flags", {c0, o0, d0, z0, rdy0, c1, z1, rdy1}, 8'b0001_0010);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // Monitor: notes each start/handshake taken by the DUT, checks one edge later.
  initial begin
    bit   ev;
    exp_t e;
    forever begin
      @(negedge clk);
      ev = (start === 1'b1) || ((in_valid === 1'b1) && (rdy0 === 1'b1));
      chk("in_ready", {rdy0, rdy1}, {exp_ready, exp_ready});
      chk("B_passthru", {B0, B1}, {din, din});
      @(posedge clk);
      #1;
      if (ev) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_update: actual=DUT took a beat expected=no beat");
        end else begin
          e = sbq.pop_front();
          chk("result{S0,c0,o0,S1,c1,o1,cnt0,cnt1,d0,d1,z0,z1,A0,A1}",
              {S0, c0, o0, S1, c1, o1, cnt0, cnt1, d0, d1, z0, z1, A0, A1},
              {N'(e.s0), e.c0, e.o0, N'(e.s1), e.c1, e.o1, CW'(e.cnt), CW'(e.cnt),
               e.dn, e.dn, (e.s0 == 0), (e.s1 == 0), N'(e.s0), N'(e.s1)});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mode = 2'b11; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    idle();
    chk("reset_state", {S0, cnt0, d0, z0, rdy0}, {8'd0, 3'd0, 1'b0, 1'b1, 1'b0});

    // 1: 200 + 100 wraps to 44 with carry.
    beat(1'b1, 1'b0, 2'b11, 0);
    beat(1'b0, 1'b1, 2'b00, 200);
    beat(1'b0, 1'b1, 2'b01, 100);
    idle();
    chk("t1_wrap", {S0, c0, o0, cnt0}, {8'd44, 1'b1, 1'b0, 3'd2});
    chk("t3_sat_add", {S1, c1}, {8'd255, 1'b1});

    // 2: signed overflow, then a borrow.
    beat(1'b1, 1'b0, 2'b11, 0);
    beat(1'b0, 1'b1, 2'b00, 100);
    beat(1'b0, 1'b1, 2'b01, 100);
    idle();
    chk("t2_ovf", {S0, c0, o0}, {8'd200, 1'b0, 1'b1});
    beat(1'b0, 1'b1, 2'b10, 201);
    idle();
    chk("t2_borrow", {S0, c0, o0}, {8'd255, 1'b1, 1'b0});

    // 3/4: clamped subtract fills the batch with gaps; a 5th beat is ignored.
    beat(1'b1, 1'b0, 2'b11, 0);
    beat(1'b0, 1'b1, 2'b00, 200);
    idle();
    beat(1'b0, 1'b1, 2'b01, 100);
    idle();
    idle();
    beat(1'b0, 1'b1, 2'b00, 5);
    idle();
    beat(1'b0, 1'b1, 2'b10, 7);
    idle();
    chk("t3_sat_sub", {S1, c1, d1, cnt1}, {8'd0, 1'b1, 1'b1, 3'd4});
    beat(1'b0, 1'b1, 2'b01, 9);
    idle();
    chk("t4_held", {S0, d0, rdy0}, {8'd254, 1'b1, 1'b0});
    beat(1'b1, 1'b0, 2'b11, 0);
    idle();
    chk("t4_restart", {S0, cnt0, d0, z0}, {8'd0, 3'd0, 1'b0, 1'b1});

    // 5: a beat coincident with start is dropped.
    beat(1'b0, 1'b1, 2'b00, 77);
    beat(1'b1, 1'b1, 2'b01, 50);
    idle();
    chk("t5_drop", {S0, cnt0}, {8'd0, 3'd0});

    // 6: asynchronous reset mid-batch, then beats ignored until start.
    beat(1'b0, 1'b1, 2'b00, 200);
    beat(1'b0, 1'b1, 2'b01, 100);
    idle();
    chk("t6_pre", {S0, cnt0}, {8'd44, 3'd2});
    async_reset();
    repeat (3) beat(1'b0, 1'b1, 2'b01, 33);
    idle();
    chk("t6_ignored", {S0, cnt0, rdy0}, {8'd0, 3'd0, 1'b0});

    // Randomised batches.
    for (int i = 0; i < 600; i++) begin
      beat($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0)
                                       : int'($urandom_range(0, 255)));
    end
    idle();
    idle();
    idle();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
